// File: rtl/int2flt_arbiter.sv
// Round-robin front end sharing one int-to-float converter among NUM_REQ clients.
// Optional: define INT2FLT_ZERO_BYPASS_EN to answer a zero operand without using the converter.
module int2flt_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int CVT_LAT = 0,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*32-1:0]  req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   rsp_valid,
    output logic [31:0]            rsp_data,
    output logic [ID_W-1:0]        rsp_id,
    input  logic                   rsp_ready,
    output logic                   cvt_start,
    output logic [31:0]            cvt_int,
    input  logic [31:0]            cvt_flt,
    output logic                   busy
);

`ifdef INT2FLT_ZERO_BYPASS_EN
    localparam bit ZERO_BYPASS = 1'b1;
`else
    localparam bit ZERO_BYPASS = 1'b0;
`endif

    // lat_cnt only ever holds CVT_LAT-1 down to 0.
    localparam int             LAT_W    = (CVT_LAT > 2) ? $clog2(CVT_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'((CVT_LAT > 0) ? CVT_LAT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e            state_q,    state_d;
    logic [ID_W-1:0]   rr_ptr_q,   rr_ptr_d;
    logic [ID_W-1:0]   rsp_id_q,   rsp_id_d;
    logic [31:0]       cvt_int_q,  cvt_int_d;
    logic [31:0]       rsp_data_q, rsp_data_d;
    logic [LAT_W-1:0]  lat_cnt_q,  lat_cnt_d;

    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic [ID_W-1:0]   scan_idx;
    logic [31:0]       grant_data;

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (int'(rr_ptr_q) + k >= NUM_REQ) begin
                scan_idx = ID_W'(int'(rr_ptr_q) + k - NUM_REQ);
            end else begin
                scan_idx = ID_W'(int'(rr_ptr_q) + k);
            end
            if (!grant_found && req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    assign grant_data = req_data[32*grant_idx +: 32];

    always_comb begin
        // NOTE: every variable gets its hold value first, so no path through the case leaves one unassigned and infers a latch.
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        rsp_id_d   = rsp_id_q;
        cvt_int_d  = cvt_int_q;
        rsp_data_d = rsp_data_q;
        lat_cnt_d  = lat_cnt_q;
        req_ready  = '0;

        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    req_ready[grant_idx] = rst_n;
                    rsp_id_d             = grant_idx;
                    if (ZERO_BYPASS && grant_data == 32'h0) begin
                        rsp_data_d = 32'h0000_0000;
                        state_d    = RESP;
                    end else begin
                        cvt_int_d = grant_data;
                        state_d   = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (CVT_LAT == 0) begin
                    rsp_data_d = cvt_flt;
                    state_d    = RESP;
                end else begin
                    lat_cnt_d = LAT_LOAD;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (lat_cnt_q == '0) begin
                    rsp_data_d = cvt_flt;
                    state_d    = RESP;
                end else begin
                    lat_cnt_d = lat_cnt_q - LAT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rr_ptr_d = (rsp_id_q == ID_W'(NUM_REQ - 1)) ? '0 : rsp_id_q + ID_W'(1);
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset drops any in-flight transaction; nothing is replayed afterwards.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            rsp_id_q   <= '0;
            cvt_int_q  <= '0;
            rsp_data_q <= '0;
            lat_cnt_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments make every _q take its _d together at the edge, independent of statement order.
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            rsp_id_q   <= rsp_id_d;
            cvt_int_q  <= cvt_int_d;
            rsp_data_q <= rsp_data_d;
            lat_cnt_q  <= lat_cnt_d;
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign cvt_start = (state_q == ISSUE);
    assign busy      = (state_q != IDLE);
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign cvt_int   = cvt_int_q;

endmodule

// File: tb/tb_int2flt_arbiter.sv
// Directed bench for int2flt_arbiter: one instance with CVT_LAT=0, one with CVT_LAT=3.
module tb_int2flt_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic [3:0]   req_valid0, req_ready0;
    logic [127:0] req_data0;
    logic         rsp_valid0, rsp_ready0, cvt_start0, busy0;
    logic [31:0]  rsp_data0, cvt_int0, cvt_flt0;
    logic [1:0]   rsp_id0;

    logic [3:0]   req_valid3, req_ready3;
    logic [127:0] req_data3;
    logic         rsp_valid3, rsp_ready3, cvt_start3, busy3;
    logic [31:0]  rsp_data3, cvt_int3, cvt_flt3;
    logic [1:0]   rsp_id3;

    int n_checks = 0;
    int n_errors = 0;

    // Reference converter used as the shared unit's stand-in.
    function automatic logic [31:0] i2f(input logic [31:0] v);
        logic [31:0] mag;
        logic [31:0] norm;
        int          msb;
        if (v == 32'h0) return 32'h0;
        mag = v[31] ? (~v + 32'd1) : v;
        msb = 0;
        for (int b = 0; b < 32; b++) if (mag[b]) msb = b;
        norm = mag << (31 - msb);
        return {v[31], 8'(127 + msb), norm[30:8]};
    endfunction

    assign cvt_flt0 = i2f(cvt_int0);

    logic [31:0] pipe1, pipe2, pipe3;
    always @(posedge clk) begin
        pipe1 <= i2f(cvt_int3);
        pipe2 <= pipe1;
        pipe3 <= pipe2;
    end
    assign cvt_flt3 = pipe3;

    int2flt_arbiter #(.NUM_REQ(4), .CVT_LAT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid0), .req_data(req_data0), .req_ready(req_ready0),
        .rsp_valid(rsp_valid0), .rsp_data(rsp_data0), .rsp_id(rsp_id0), .rsp_ready(rsp_ready0),
        .cvt_start(cvt_start0), .cvt_int(cvt_int0), .cvt_flt(cvt_flt0), .busy(busy0)
    );

    int2flt_arbiter #(.NUM_REQ(4), .CVT_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid3), .req_data(req_data3), .req_ready(req_ready3),
        .rsp_valid(rsp_valid3), .rsp_data(rsp_data3), .rsp_id(rsp_id3), .rsp_ready(rsp_ready3),
        .cvt_start(cvt_start3), .cvt_int(cvt_int3), .cvt_flt(cvt_flt3), .busy(busy3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] rr_int [4] = '{32'd2, 32'd3, 32'd4, 32'd5};
    logic [31:0] rr_flt [4] = '{32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h40A0_0000};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int exp_id;
        rst_n      = 1'b0;
        req_valid0 = '0; req_data0 = '0; rsp_ready0 = 1'b1;
        req_valid3 = '0; req_data3 = '0; rsp_ready3 = 1'b1;
        tick();
        tick();

        // Reset state, with every request asserted to show req_ready is held low.
        req_valid0 = 4'hF; req_valid3 = 4'hF; #1;
        check("rst_req_ready0", req_ready0, 4'h0);
        check("rst_req_ready3", req_ready3, 4'h0);
        check("rst_rsp_valid",  rsp_valid0, 1'b0);
        check("rst_rsp_data",   rsp_data0,  32'h0);
        check("rst_rsp_id",     rsp_id0,    2'd0);
        check("rst_cvt_start",  cvt_start0, 1'b0);
        check("rst_cvt_int",    cvt_int0,   32'h0);
        check("rst_busy",       busy0,      1'b0);
        req_valid0 = '0; req_valid3 = '0;
        rst_n = 1'b1;
        tick();

        // Single request, CVT_LAT=0.
        req_data0[31:0] = 32'd1; req_valid0 = 4'b0001; #1;
        check("t1_ready", req_ready0, 4'b0001);
        check("t1_busy_idle", busy0, 1'b0);
        tick(); req_valid0 = '0; #1;
        check("t1_start", cvt_start0, 1'b1);
        check("t1_cvt_int", cvt_int0, 32'd1);
        check("t1_valid_early", rsp_valid0, 1'b0);
        check("t1_busy", busy0, 1'b1);
        tick();
        check("t1_rsp_valid", rsp_valid0, 1'b1);
        check("t1_rsp_data", rsp_data0, 32'h3F80_0000);
        check("t1_rsp_id", rsp_id0, 2'd0);
        check("t1_start_once", cvt_start0, 1'b0);
        tick();
        check("t1_valid_drop", rsp_valid0, 1'b0);
        check("t1_idle", busy0, 1'b0);

        // All four requesters held high from reset: grants 0,1,2,3,0.
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) req_data0[32*i +: 32] = rr_int[i];
        req_valid0 = 4'hF;
        tick();
        check("rr_rst_ready", req_ready0, 4'h0);
        rst_n = 1'b1; #1;
        for (int g = 0; g < 5; g++) begin
            exp_id = g % 4;
            check($sformatf("rr%0d_ready", g), req_ready0, 32'd1 << exp_id);
            tick();
            check($sformatf("rr%0d_start", g), cvt_start0, 1'b1);
            check($sformatf("rr%0d_cvt_int", g), cvt_int0, rr_int[exp_id]);
            tick();
            check($sformatf("rr%0d_valid", g), rsp_valid0, 1'b1);
            check($sformatf("rr%0d_id", g), rsp_id0, 32'(exp_id));
            check($sformatf("rr%0d_data", g), rsp_data0, rr_flt[exp_id]);
            tick();
        end

        // Backpressure: only requester 2 valid (rr_ptr is 1), consumer stalls 5 cycles.
        req_valid0 = 4'b0100; rsp_ready0 = 1'b0; #1;
        check("bp_ready", req_ready0, 4'b0100);
        tick(); req_valid0 = 4'hF; #1;
        check("bp_issue_ready", req_ready0, 4'h0);
        tick();
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bp%0d_valid", c), rsp_valid0, 1'b1);
            check($sformatf("bp%0d_data", c), rsp_data0, 32'h4080_0000);
            check($sformatf("bp%0d_id", c), rsp_id0, 2'd2);
            check($sformatf("bp%0d_ready", c), req_ready0, 4'h0);
            check($sformatf("bp%0d_busy", c), busy0, 1'b1);
            tick();
        end
        rsp_ready0 = 1'b1; #1;
        check("bp_held", rsp_valid0, 1'b1);
        tick();
        check("bp_valid_drop", rsp_valid0, 1'b0);
        check("bp_next_ptr", req_ready0, 4'b1000);
        req_valid0 = '0; #1;

        // Zero operand through DUT0.
        req_data0[31:0] = 32'h0; req_valid0 = 4'b0001; #1;
        check("z_ready", req_ready0, 4'b0001);
        tick(); req_valid0 = '0; #1;
`ifdef INT2FLT_ZERO_BYPASS_EN
        check("z_valid", rsp_valid0, 1'b1);
        check("z_data", rsp_data0, 32'h0);
        check("z_id", rsp_id0, 2'd0);
        check("z_start", cvt_start0, 1'b0);
        check("z_cvt_int_kept", cvt_int0, 32'd4);
`else
        check("z_start", cvt_start0, 1'b1);
        check("z_cvt_int", cvt_int0, 32'h0);
        check("z_valid_early", rsp_valid0, 1'b0);
        tick();
        check("z_valid", rsp_valid0, 1'b1);
        check("z_data", rsp_data0, 32'h0);
        check("z_id", rsp_id0, 2'd0);
        check("z_start_once", cvt_start0, 1'b0);
`endif
        tick();
        check("z_done", rsp_valid0, 1'b0);

        // CVT_LAT=3: requester 2 sends 18.
        req_data3[95:64] = 32'd18; req_valid3 = 4'b0100; #1;
        check("l3_ready", req_ready3, 4'b0100);
        tick(); req_valid3 = '0; #1;
        check("l3_start", cvt_start3, 1'b1);
        check("l3_cvt_int", cvt_int3, 32'd18);
        check("l3_valid_issue", rsp_valid3, 1'b0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("l3w%0d_start", c), cvt_start3, 1'b0);
            check($sformatf("l3w%0d_cvt_int", c), cvt_int3, 32'd18);
            check($sformatf("l3w%0d_valid", c), rsp_valid3, 1'b0);
            check($sformatf("l3w%0d_busy", c), busy3, 1'b1);
        end
        tick();
        check("l3_valid", rsp_valid3, 1'b1);
        check("l3_data", rsp_data3, 32'h4190_0000);
        check("l3_id", rsp_id3, 2'd2);
        tick();
        check("l3_valid_drop", rsp_valid3, 1'b0);
        check("l3_idle", busy3, 1'b0);

        // Reset during WAIT drops the transaction; rr_ptr returns to 0.
        req_data3[31:0] = 32'd7; req_valid3 = 4'b0001; #1;
        check("rw_ready", req_ready3, 4'b0001);
        tick(); req_valid3 = '0;
        tick();
        check("rw_in_wait", busy3, 1'b1);
        rst_n = 1'b0;
        tick();
        req_valid3 = 4'b1010; #1;
        check("rw_req_ready", req_ready3, 4'h0);
        check("rw_rsp_valid", rsp_valid3, 1'b0);
        check("rw_rsp_data",  rsp_data3,  32'h0);
        check("rw_rsp_id",    rsp_id3,    2'd0);
        check("rw_cvt_start", cvt_start3, 1'b0);
        check("rw_cvt_int",   cvt_int3,   32'h0);
        check("rw_busy",      busy3,      1'b0);
        rst_n = 1'b1;
        req_data3[63:32] = 32'd9; req_data3[127:96] = 32'd11; #1;
        check("rw_rr_ptr0", req_ready3, 4'b0010);
        tick(); req_valid3 = '0; #1;
        check("rw_start", cvt_start3, 1'b1);
        check("rw_cvt_int_new", cvt_int3, 32'd9);
        check("rw_valid_a1", rsp_valid3, 1'b0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("rw_valid_w%0d", c), rsp_valid3, 1'b0);
        end
        tick();
        check("rw_valid", rsp_valid3, 1'b1);
        check("rw_id", rsp_id3, 2'd1);
        check("rw_data", rsp_data3, 32'h4110_0000);
        tick();
        check("rw_valid_drop", rsp_valid3, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
